// File: rtl/custom_sort_pkg.sv
// Shared types for the sort/unsort datapath: FSM states, index width, frame beat.
// Consumed by custom_unsort (optional build macro: CUSTOM_UNSORT_ORDER_CHECK_EN).
package custom_sort_pkg;

    typedef enum logic [0:0] {
        ST_FILL  = 1'b0,
        ST_DRAIN = 1'b1
    } state_e;

    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int WIDTH    = 8;
    localparam int DEF_N    = 6;
    localparam int DEF_IDXW = idx_width(DEF_N);

    typedef struct packed {
        logic [WIDTH-1:0]    data;
        logic [DEF_IDXW-1:0] idx;
    } beat_t;

endpackage

// File: rtl/custom_unsort_buf.sv
// Scatter buffer: N slots plus occupancy, write-once per frame, zero-fill reads.
// Writes to occupied or out-of-range slots report a miss and are ignored.
module custom_unsort_buf
    import custom_sort_pkg::*;
#(
    parameter int N     = 6,
    parameter int WIDTH = 8,
    parameter int IDXW  = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             wr_en_i,
    input  logic [IDXW-1:0]  wr_idx_i,
    input  logic [WIDTH-1:0] wr_data_i,
    output logic             wr_hit_o,
    input  logic [IDXW-1:0]  rd_idx_i,
    output logic [WIDTH-1:0] rd_data_o
);

    logic [WIDTH-1:0] mem_q [N];
    logic [N-1:0]     occ_q;

    // Index values >= N match no slot, so they miss naturally.
    always_comb begin
        wr_hit_o = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (wr_idx_i == IDXW'(i)) begin
                wr_hit_o = !occ_q[i];
            end
        end
    end

    always_comb begin
        rd_data_o = '0;
        for (int i = 0; i < N; i++) begin
            if (rd_idx_i == IDXW'(i) && occ_q[i]) begin
                rd_data_o = mem_q[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clr_i) begin
            occ_q <= '0;
        end else if (wr_en_i && wr_hit_o) begin
            for (int i = 0; i < N; i++) begin
                if (wr_idx_i == IDXW'(i)) begin
                    mem_q[i] <= wr_data_i;
                    occ_q[i] <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/custom_unsort.sv
// Streaming un-sorter: scatters a sorted frame by original index, drains in order.
// Build macro CUSTOM_UNSORT_ORDER_CHECK_EN adds the order_err input-order monitor.
module custom_unsort
    import custom_sort_pkg::*;
#(
    parameter  int N     = 6,
    parameter  int WIDTH = 8,
    localparam int IDXW  = idx_width(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [IDXW-1:0]  in_idx,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [IDXW-1:0]  out_idx,
    output logic             out_last,
`ifdef CUSTOM_UNSORT_ORDER_CHECK_EN
    output logic             order_err,
`endif
    output logic             dup_err
);

    localparam int CW = IDXW + 1;

    state_e           state_q;
    logic [CW-1:0]    in_cnt_q;
    logic [CW-1:0]    rd_ptr_q;
    logic             dup_err_q;
    logic             drain;
    logic             in_hs;
    logic             out_hs;
    logic             last;
    logic             wr_hit;
    logic [WIDTH-1:0] rd_data;

    assign drain  = (state_q == ST_DRAIN);
    assign last   = drain && (rd_ptr_q == CW'(N - 1));
    assign in_hs  = in_valid && !drain;
    assign out_hs = drain && out_ready;

    assign in_ready  = !drain;
    assign out_valid = drain;
    assign out_idx   = drain ? rd_ptr_q[IDXW-1:0] : '0;
    assign out_data  = drain ? rd_data : '0;
    assign out_last  = last;
    assign dup_err   = dup_err_q;

    custom_unsort_buf #(
        .N     (N),
        .WIDTH (WIDTH),
        .IDXW  (IDXW)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (out_hs && last),
        .wr_en_i   (in_hs),
        .wr_idx_i  (in_idx),
        .wr_data_i (in_data),
        .wr_hit_o  (wr_hit),
        .rd_idx_i  (rd_ptr_q[IDXW-1:0]),
        .rd_data_o (rd_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_FILL;
            in_cnt_q  <= '0;
            rd_ptr_q  <= '0;
            dup_err_q <= 1'b0;
        end else begin
            unique case (state_q)
                ST_FILL: begin
                    if (in_hs) begin
                        if (!wr_hit) begin
                            dup_err_q <= 1'b1;
                        end
                        if (in_cnt_q == CW'(N - 1)) begin
                            in_cnt_q <= '0;
                            state_q  <= ST_DRAIN;
                        end else begin
                            in_cnt_q <= in_cnt_q + 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (out_hs) begin
                        if (last) begin
                            state_q   <= ST_FILL;
                            rd_ptr_q  <= '0;
                            dup_err_q <= 1'b0;
                        end else begin
                            rd_ptr_q <= rd_ptr_q + 1'b1;
                        end
                    end
                end
                default: state_q <= ST_FILL;
            endcase
        end
    end

`ifdef CUSTOM_UNSORT_ORDER_CHECK_EN
    logic [WIDTH-1:0] prev_q;
    logic             order_err_q;

    assign order_err = order_err_q;

    // The first beat of a frame has no predecessor to compare with.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_q      <= '0;
            order_err_q <= 1'b0;
        end else if (in_hs) begin
            prev_q <= in_data;
            if (in_cnt_q != '0 && in_data < prev_q) begin
                order_err_q <= 1'b1;
            end
        end else if (out_hs && last) begin
            order_err_q <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_custom_unsort.sv
// Directed bench for custom_unsort with a scoreboard of expected output beats.
// Optional build macro CUSTOM_UNSORT_ORDER_CHECK_EN also checks order_err.
module tb_custom_unsort;

    localparam int N = 6;
    localparam int W = 8;
    localparam int IW = 3;

    typedef struct {
        logic [W-1:0]  data;
        logic [IW-1:0] idx;
        logic          last;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data = '0;
    logic [IW-1:0] in_idx = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_data;
    logic [IW-1:0] out_idx;
    logic          out_last;
    logic          dup_err;
`ifdef CUSTOM_UNSORT_ORDER_CHECK_EN
    logic          order_err;
`endif

    int tests = 0;
    int fails = 0;
    exp_t q[$];
    logic [W-1:0]  fd [N];
    logic [IW-1:0] fi [N];
    logic exp_dup;
    logic exp_ord;

    always #5 clk = ~clk;

    custom_unsort #(.N(N), .WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_idx    (in_idx),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
`ifdef CUSTOM_UNSORT_ORDER_CHECK_EN
        .order_err (order_err),
`endif
        .dup_err   (dup_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Model: first write per slot wins, bad indices dropped, empty slots read 0.
    task automatic send_frame();
        logic [W-1:0] md [N];
        logic [N-1:0] occ;
        logic [W-1:0] prev;
        exp_t e;
        occ = '0;
        prev = '0;
        exp_dup = 1'b0;
        exp_ord = 1'b0;
        for (int i = 0; i < N; i++) md[i] = '0;
        for (int k = 0; k < N; k++) begin
            if (int'(fi[k]) < N && !occ[fi[k]]) begin
                md[fi[k]] = fd[k];
                occ[fi[k]] = 1'b1;
            end else begin
                exp_dup = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            e.data = md[i];
            e.idx = IW'(i);
            e.last = (i == N - 1);
            q.push_back(e);
        end
        for (int k = 0; k < N; k++) begin
            @(negedge clk);
`ifdef CUSTOM_UNSORT_ORDER_CHECK_EN
            if (k > 0) chk("order_err_beat", 32'(order_err), 32'(exp_ord));
            if (k > 0 && fd[k] < prev) exp_ord = 1'b1;
`endif
            prev = fd[k];
            chk("in_ready_fill", 32'(in_ready), 32'd1);
            chk("out_valid_fill", 32'(out_valid), 32'd0);
            in_valid = 1'b1;
            in_data = fd[k];
            in_idx = fi[k];
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk("latency_out_valid", 32'(out_valid), 32'd1);
        chk("in_ready_drain", 32'(in_ready), 32'd0);
        chk("dup_err_frame", 32'(dup_err), 32'(exp_dup));
`ifdef CUSTOM_UNSORT_ORDER_CHECK_EN
        chk("order_err_frame", 32'(order_err), 32'(exp_ord));
`endif
    endtask

    // pat 0: always ready; pat 1: ready 1,0,0 repeating. Stops after nmax beats.
    task automatic drain_frame(input int pat, input int nmax);
        int hs;
        int cyc;
        bit done;
        exp_t e;
        hs = 0;
        cyc = 0;
        done = 0;
        while (!done && cyc < 100) begin
            if (cyc > 0) @(negedge clk);
            out_ready = (pat == 0) ? 1'b1 : (cyc % 3 == 0);
            chk("in_ready_drain", 32'(in_ready), 32'd0);
            if (out_valid && q.size() > 0) begin
                e = q[0];
                chk("out_data", 32'(out_data), 32'(e.data));
                chk("out_idx", 32'(out_idx), 32'(e.idx));
                chk("out_last", 32'(out_last), 32'(e.last));
                chk("dup_err_drain", 32'(dup_err), 32'(exp_dup));
                if (out_ready) begin
                    void'(q.pop_front());
                    hs++;
                    if (e.last || hs == nmax) done = 1;
                end
            end else begin
                chk("out_valid_drain", 32'(out_valid), 32'd1);
                done = 1;
            end
            cyc++;
        end
        chk("drain_no_timeout", 32'(done), 32'd1);
        chk("drain_handshakes", 32'(hs), 32'(nmax));
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_dup_err"}, 32'(dup_err), 32'd0);
        chk({tag, "_out_last"}, 32'(out_last), 32'd0);
`ifdef CUSTOM_UNSORT_ORDER_CHECK_EN
        chk({tag, "_order_err"}, 32'(order_err), 32'd0);
`endif
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_idx", 32'(out_idx), 32'd0);
        check_idle("rst");
        rst_n = 1'b1;

        fd = '{3, 5, 7, 9, 12, 20};
        fi = '{4, 0, 2, 5, 1, 3};
        send_frame();
        drain_frame(0, N);
        check_idle("normal_end");

        fd = '{1, 2, 3, 4, 5, 6};
        fi = '{0, 0, 1, 2, 3, 4};
        send_frame();
        drain_frame(0, N);
        check_idle("dup_end");

        fd = '{10, 20, 30, 40, 50, 60};
        fi = '{0, 1, 7, 3, 4, 5};
        send_frame();
        drain_frame(0, N);
        check_idle("oor_end");

        fd = '{8, 6, 4, 2, 1, 0};
        fi = '{5, 4, 3, 2, 1, 0};
        send_frame();
        drain_frame(1, N);
        check_idle("bp_end");

        fd = '{11, 22, 33, 44, 55, 66};
        fi = '{2, 3, 4, 5, 0, 1};
        send_frame();
        drain_frame(0, 3);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_idle("mid_rst");
        q.delete();

        fd = '{7, 7, 9, 1, 2, 3};
        fi = '{1, 1, 2, 3, 4, 5};
        send_frame();
        drain_frame(0, N);
        check_idle("post_rst_end");

        fd = '{3, 9, 5, 10, 11, 12};
        fi = '{0, 1, 2, 3, 4, 5};
        send_frame();
        drain_frame(0, N);
        check_idle("order_end");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
